// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor updates.
// Optional phase-align input enabled by defining CLKDIV_MULTI_SYNC_EN.
module clkdiv_multi #(
    parameter  int unsigned CHANNELS     = 2,
    parameter  int unsigned WIDTH        = 16,
    parameter  int unsigned DEFAULT_HALF = 8,
    localparam int unsigned CHW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [CHANNELS-1:0] i_en,
    input  logic                i_sync,
    input  logic                i_wr_valid,
    output logic                o_wr_ready,
    input  logic [CHW-1:0]      i_wr_ch,
    input  logic [WIDTH-1:0]    i_wr_half,
    output logic [CHANNELS-1:0] o_clk_div,
    output logic [CHANNELS-1:0] o_tick
);

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_RUN,
        MODE_DRAIN
    } mode_t;

    mode_t               mode   [CHANNELS];
    logic [WIDTH-1:0]    half_q [CHANNELS];
    logic [WIDTH-1:0]    half_d [CHANNELS];
    logic [WIDTH-1:0]    cnt_q  [CHANNELS];
    logic [WIDTH-1:0]    cnt_d  [CHANNELS];
    logic [WIDTH-1:0]    pval_q [CHANNELS];
    logic [WIDTH-1:0]    pval_d [CHANNELS];
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] clk_q, clk_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] wr_hit;
    logic [(1<<CHW)-1:0] pend_pad;
    logic                wr_ready;

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                half_q[n] <= WIDTH'(DEFAULT_HALF);
                cnt_q[n]  <= '0;
                pval_q[n] <= '0;
            end
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                half_q[n] <= half_d[n];
                cnt_q[n]  <= cnt_d[n];
                pval_q[n] <= pval_d[n];
            end
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            if (half_q[n] == '0)
                mode[n] = MODE_IDLE;
            else if (i_en[n])
                mode[n] = MODE_RUN;
            else if (clk_q[n])
                mode[n] = MODE_DRAIN;
            else
                mode[n] = MODE_IDLE;
        end
    end

    // Next-state logic. A pending H=0 applied at a boundary forces the output
    // low there, so stopping never leaves a one-cycle runt high pulse.
    always_comb begin
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            half_d[n] = half_q[n];
            cnt_d[n]  = cnt_q[n];
            pval_d[n] = pval_q[n];
            pend_d[n] = pend_q[n];
            clk_d[n]  = clk_q[n];
            tick_d[n] = 1'b0;
            case (mode[n])
                MODE_RUN, MODE_DRAIN: begin
                    if (cnt_q[n] == half_q[n] - WIDTH'(1)) begin
                        cnt_d[n] = '0;
                        clk_d[n] = (mode[n] == MODE_RUN) ? ~clk_q[n] : 1'b0;
                        if (pend_q[n]) begin
                            half_d[n] = pval_q[n];
                            pend_d[n] = 1'b0;
                            if (pval_q[n] == '0)
                                clk_d[n] = 1'b0;
                        end
                    end else begin
                        cnt_d[n] = cnt_q[n] + WIDTH'(1);
                    end
                end
                default: begin
                    cnt_d[n] = '0;
                    clk_d[n] = 1'b0;
                    if (pend_q[n]) begin
                        half_d[n] = pval_q[n];
                        pend_d[n] = 1'b0;
                    end
                end
            endcase
`ifdef CLKDIV_MULTI_SYNC_EN
            if (i_sync && i_en[n]) begin
                cnt_d[n] = '0;
                clk_d[n] = 1'b0;
                if (pend_q[n]) begin
                    half_d[n] = pval_q[n];
                    pend_d[n] = 1'b0;
                end
            end
`endif
            tick_d[n] = ~clk_q[n] & clk_d[n];
            // Ready gating means a write never lands while pend_q is set
            if (wr_hit[n]) begin
                pval_d[n] = i_wr_half;
                pend_d[n] = 1'b1;
            end
        end
    end

`ifndef CLKDIV_MULTI_SYNC_EN
    logic unused_sync;
    assign unused_sync = i_sync;
`endif

    // Outputs; out-of-range channel numbers see a zero pending bit and are dropped
    always_comb begin
        pend_pad                 = '0;
        pend_pad[CHANNELS-1:0]   = pend_q;
        wr_ready                 = ~pend_pad[i_wr_ch];
        for (int unsigned n = 0; n < CHANNELS; n++)
            wr_hit[n] = i_wr_valid && wr_ready && (i_wr_ch == CHW'(n));
    end

    assign o_wr_ready = wr_ready;
    assign o_clk_div  = clk_q;
    assign o_tick     = tick_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed self-checking bench for clkdiv_multi (CHANNELS=2, WIDTH=16, DEFAULT_HALF=8).
module tb_clkdiv_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  en = '0;
    logic        sync = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [0:0]  wr_ch = '0;
    logic [15:0] wr_half = '0;
    logic [1:0]  clk_div;
    logic [1:0]  tick;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    clkdiv_multi #(.CHANNELS(2), .WIDTH(16), .DEFAULT_HALF(8)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_en       (en),
        .i_sync     (sync),
        .i_wr_valid (wr_valid),
        .o_wr_ready (wr_ready),
        .i_wr_ch    (wr_ch),
        .i_wr_half  (wr_half),
        .o_clk_div  (clk_div),
        .o_tick     (tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
        cyc++;
    endtask

    // Free-running divider seen d cycles after its phase origin
    function automatic logic exp_clk(input int d, input int h);
        if (d < 0) return 1'b0;
        return ((d / h) % 2) == 1;
    endfunction

    function automatic logic exp_tick(input int d, input int h);
        return (d > 0) && ((d % (2 * h)) == h);
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = '0;
        sync     = 1'b0;
        wr_valid = 1'b0;
        wr_ch    = '0;
        wr_half  = '0;
        next();
        next();
        check("rst_clk", 32'(clk_div), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_rdy0", 32'(wr_ready), 32'd1);
        wr_ch = 1'b1;
        #1;
        check("rst_rdy1", 32'(wr_ready), 32'd1);
        wr_ch = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int c0, c1, cs, d, o0, o1;

        // Defaults: channel 0 at H=8, channel 1 disabled
        do_reset();
        en = 2'b01;
        c0 = cyc;
        for (int i = 0; i < 40; i++) begin
            next();
            d = cyc - c0;
            check($sformatf("t1_clk0 d%0d", d), 32'(clk_div[0]), 32'(exp_clk(d, 8)));
            check($sformatf("t1_tick0 d%0d", d), 32'(tick[0]), 32'(exp_tick(d, 8)));
            check($sformatf("t1_ch1 d%0d", d), 32'({clk_div[1], tick[1]}), 32'd0);
        end

        // Glitch-free update: H=3 written mid-high, second write refused
        do_reset();
        en = 2'b01;
        c0 = cyc;
        for (int i = 0; i < 36; i++) begin
            next();
            d = cyc - c0;
            if (d < 16) begin
                check($sformatf("t2_clk d%0d", d), 32'(clk_div[0]), 32'(exp_clk(d, 8)));
                check($sformatf("t2_tick d%0d", d), 32'(tick[0]), 32'(exp_tick(d, 8)));
            end else begin
                check($sformatf("t2_clk d%0d", d), 32'(clk_div[0]), 32'(exp_clk(d - 16, 3)));
                check($sformatf("t2_tick d%0d", d), 32'(tick[0]), 32'(exp_tick(d - 16, 3)));
            end
            check($sformatf("t2_rdy d%0d", d), 32'(wr_ready), (d >= 11 && d <= 15) ? 32'd0 : 32'd1);
            if (d == 10) begin
                wr_valid = 1'b1;
                wr_half  = 16'd3;
            end else if (d == 11) begin
                wr_half  = 16'd5;
            end else if (d == 12) begin
                wr_valid = 1'b0;
            end
        end

        // Drain: H=5, disable with channel high and 2 cycles elapsed
        do_reset();
        wr_valid = 1'b1;
        wr_half  = 16'd5;
        next();
        wr_valid = 1'b0;
        next();
        next();
        check("t3_rdy", 32'(wr_ready), 32'd1);
        en = 2'b01;
        c0 = cyc;
        for (int i = 0; i < 20; i++) begin
            next();
            d = cyc - c0;
            check($sformatf("t3_clk d%0d", d), 32'(clk_div[0]), (d <= 9) ? 32'(exp_clk(d, 5)) : 32'd0);
            check($sformatf("t3_tick d%0d", d), 32'(tick[0]), (d <= 9) ? 32'(exp_tick(d, 5)) : 32'd0);
            if (d == 7) en = 2'b00;
        end

        // Stop with H=0, then H=1 applied while idle
        do_reset();
        en = 2'b01;
        c0 = cyc;
        for (int i = 0; i < 26; i++) begin
            next();
            d = cyc - c0;
            check($sformatf("t4_clk d%0d", d), 32'(clk_div[0]), 32'd0);
            check($sformatf("t4_tick d%0d", d), 32'(tick[0]), 32'd0);
            check($sformatf("t4_rdy d%0d", d), 32'(wr_ready),
                  ((d >= 4 && d <= 7) || d == 21) ? 32'd0 : 32'd1);
            if (d == 3) begin
                wr_valid = 1'b1;
                wr_half  = 16'd0;
            end else if (d == 4) begin
                wr_valid = 1'b0;
            end else if (d == 20) begin
                en       = 2'b00;
                wr_valid = 1'b1;
                wr_half  = 16'd1;
            end else if (d == 21) begin
                wr_valid = 1'b0;
            end
        end
        en = 2'b01;
        c1 = cyc;
        for (int i = 0; i < 10; i++) begin
            next();
            d = cyc - c1;
            check($sformatf("t4_div2 d%0d", d), 32'(clk_div[0]), 32'(d % 2));
            check($sformatf("t4_div2tick d%0d", d), 32'(tick[0]), 32'(d % 2));
        end

        // Sync: H=4 and H=6 started out of phase
        do_reset();
        wr_valid = 1'b1;
        wr_ch    = 1'b0;
        wr_half  = 16'd4;
        next();
        wr_ch    = 1'b1;
        wr_half  = 16'd6;
        next();
        wr_valid = 1'b0;
        next();
        next();
        en = 2'b10;
        o1 = cyc;
        next();
        en = 2'b11;
        o0 = cyc;
        cs = o1 + 7;
        for (int i = 0; i < 45; i++) begin
            next();
            check($sformatf("t5_clk0 c%0d", cyc - cs), 32'(clk_div[0]), 32'(exp_clk(cyc - o0, 4)));
            check($sformatf("t5_clk1 c%0d", cyc - cs), 32'(clk_div[1]), 32'(exp_clk(cyc - o1, 6)));
            check($sformatf("t5_tick0 c%0d", cyc - cs), 32'(tick[0]), 32'(exp_tick(cyc - o0, 4)));
            check($sformatf("t5_tick1 c%0d", cyc - cs), 32'(tick[1]), 32'(exp_tick(cyc - o1, 6)));
            if (cyc == cs) begin
                sync = 1'b1;
`ifdef CLKDIV_MULTI_SYNC_EN
                o0 = cs + 1;
                o1 = cs + 1;
`endif
            end else begin
                sync = 1'b0;
            end
        end

        // Asynchronous reset mid-operation with a write pending
        do_reset();
        en = 2'b01;
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            next();
            d = cyc - c0;
            if (d == 8) begin
                wr_valid = 1'b1;
                wr_half  = 16'd3;
            end else if (d == 9) begin
                wr_valid = 1'b0;
            end
        end
        check("t6_pre_clk", 32'(clk_div[0]), 32'd1);
        check("t6_pre_rdy", 32'(wr_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_clk", 32'(clk_div), 32'd0);
        check("t6_async_tick", 32'(tick), 32'd0);
        check("t6_async_rdy", 32'(wr_ready), 32'd1);
        next();
        rst_n = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 20; i++) begin
            next();
            d = cyc - c0;
            check($sformatf("t6_clk d%0d", d), 32'(clk_div[0]), 32'(exp_clk(d, 8)));
            check($sformatf("t6_tick d%0d", d), 32'(tick[0]), 32'(exp_tick(d, 8)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
